// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the system-RAM port arbiter.
//   arb_state_e : sequencer states (IDLE, ACCESS, DONE)
//   owner_e     : owner encoding of the granted access (OWN_CPU = 0, OWN_DMA = 1)
//   *_MIN/*_MAX : legal ranges of the MEM_LAT and STARVE_MAX parameters
//   lat_load()  : latency counter load value for a given MEM_LAT, clamped into range
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam int unsigned MEM_LAT_MIN    = 1;
    localparam int unsigned MEM_LAT_MAX    = 15;
    localparam int unsigned STARVE_MAX_MIN = 1;
    localparam int unsigned STARVE_MAX_MAX = 15;

    // The counter runs from MEM_LAT-1 down to 0, so an out-of-range latency is
    // clamped rather than allowed to wrap the 4-bit counter.
    function automatic logic [3:0] lat_load(input int unsigned lat);
        int unsigned l;
        l = lat;
        if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
        if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
        return 4'(l - 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve.sv
// mem_arb_starve: DMA starvation guard for mem_port_arbiter.
// Counts CPU grants made while DMA is waiting; once STARVE_MAX such grants have
// happened in a row, force_dma makes the next arbitration go to DMA.
// Ports:
//   clk, clr        : clock, asynchronous active-high reset
//   dma_req         : DMA request level
//   grant_cpu       : arbitration in IDLE granted the CPU this cycle
//   grant_dma       : arbitration in IDLE granted DMA this cycle
//   force_dma       : DMA must win the current arbitration
module mem_arb_starve
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic dma_req,
    input  logic grant_cpu,
    input  logic grant_dma,
    output logic force_dma
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_dma) begin
            starve_cnt_d = 4'd0;
        end else if (grant_cpu && dma_req && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_dma = dma_req && (starve_cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequencer/arbiter for the single-ported system RAM shared
// by the CPU control unit and the DMA/loader port. One access at a time:
// IDLE (arbitrate) -> ACCESS (strobes held MEM_LAT cycles) -> DONE (ack).
// Optional feature: define MEM_ARB_STARVE_EN to let a waiting DMA request win
// after STARVE_MAX consecutive CPU grants; otherwise the CPU has strict priority.
// Ports:
//   clk, clr                          : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata             : CPU request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack                : registered read data, one-cycle ack
//   cpu_stall                         : cpu_req & ~cpu_ack (combinational)
//   dma_req/we/addr/wdata/rdata/ack   : same for the DMA port
//   mem_addr/wdata/rd/wr              : registered RAM address, data and strobes
//   mem_rdata                         : RAM read data, valid in last access cycle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 9,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          clr,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LAT_INIT = lat_load(MEM_LAT);

    arb_state_e    state_q, state_d;
    owner_e        own_q, own_d;
    logic [3:0]    lat_cnt_q, lat_cnt_d;
    logic          we_q, we_d;
    // mem_addr/mem_wdata registers double as the latched access address/data.
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    logic force_dma;
    logic pick_dma;
    logic grant_cpu;
    logic grant_dma;

`ifdef MEM_ARB_STARVE_EN
    mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .clr       (clr),
        .dma_req   (dma_req),
        .grant_cpu (grant_cpu),
        .grant_dma (grant_dma),
        .force_dma (force_dma)
    );
`else
    assign force_dma = 1'b0;
`endif

    // Arbitration only takes effect in IDLE; CPU wins ties unless forced.
    assign pick_dma  = dma_req && (!cpu_req || force_dma);
    assign grant_dma = (state_q == IDLE) && pick_dma;
    assign grant_cpu = (state_q == IDLE) && cpu_req && !pick_dma;

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        lat_cnt_d   = lat_cnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_dma) begin
                    state_d     = ACCESS;
                    own_d       = OWN_DMA;
                    lat_cnt_d   = LAT_INIT;
                    we_d        = dma_we;
                    mem_addr_d  = dma_addr;
                    mem_wdata_d = dma_wdata;
                    mem_rd_d    = !dma_we;
                    mem_wr_d    = dma_we;
                end else if (grant_cpu) begin
                    state_d     = ACCESS;
                    own_d       = OWN_CPU;
                    lat_cnt_d   = LAT_INIT;
                    we_d        = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    mem_rd_d    = !cpu_we;
                    mem_wr_d    = cpu_we;
                end
            end

            ACCESS: begin
                if (lat_cnt_q == 4'd0) begin
                    // Last RAM cycle: capture read data and raise the ack for DONE.
                    state_d  = DONE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (own_q == OWN_CPU) begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) cpu_rdata_d = mem_rdata;
                    end else begin
                        dma_ack_d = 1'b1;
                        if (!we_q) dma_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // Asynchronous clear drops the strobes immediately and discards any
    // in-flight access, so no ack is ever produced for it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            own_q       <= OWN_CPU;
            lat_cnt_q   <= 4'd0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            lat_cnt_q   <= lat_cnt_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req && !cpu_ack_q;

endmodule
